// File: rtl/transmission_reciprocal_if.sv
// Pixel handshake bundle for transmission_reciprocal: dc/A/RGB in, 1/t plus aligned sidecars out.
`default_nettype none

interface transmission_reciprocal_if;
  logic        i_valid;
  logic        o_ready;
  logic [7:0]  i_dc;
  logic [7:0]  i_a;
  logic [7:0]  i_er;
  logic [7:0]  i_eg;
  logic [7:0]  i_eb;
  logic        o_valid;
  logic        i_ready;
  logic [10:0] o_on_by_t;
  logic [7:0]  o_er;
  logic [7:0]  o_eg;
  logic [7:0]  o_eb;
  logic [7:0]  o_a;

  modport master (
    output i_valid, i_dc, i_a, i_er, i_eg, i_eb, i_ready,
    input  o_ready, o_valid, o_on_by_t, o_er, o_eg, o_eb, o_a
  );

  modport slave (
    input  i_valid, i_dc, i_a, i_er, i_eg, i_eb, i_ready,
    output o_ready, o_valid, o_on_by_t, o_er, o_eg, o_eb, o_a
  );
endinterface

`default_nettype wire

// File: rtl/transmission_reciprocal.sv
// ============================================================================
// Module : transmission_reciprocal
// Brief  : 1/t = A / (A - omega*dc) with t0 floor, serial restoring divider,
//          Q8.3 output; macro DEHAZE_RECIP_ROUND_EN selects round-to-nearest.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module transmission_reciprocal #(
  parameter int unsigned OMEGA = 243,
  parameter int unsigned T0    = 26
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  transmission_reciprocal_if.slave    bus
);

`ifdef DEHAZE_RECIP_ROUND_EN
  localparam int NW = 20;
`else
  localparam int NW = 19;
`endif
  localparam logic [4:0] ITER_LAST = 5'(NW - 1);
  localparam logic [7:0] OMEGA_C   = 8'(OMEGA);
  localparam logic [7:0] T0_C      = 8'(T0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_DIV   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [7:0]    dc_q, dc_d;
  logic [7:0]    a_q, a_d;
  logic [7:0]    er_q, er_d;
  logic [7:0]    eg_q, eg_d;
  logic [7:0]    eb_q, eb_d;
  logic [15:0]   d_q, d_d;
  logic [16:0]   rem_q, rem_d;
  logic [NW-1:0] quo_q, quo_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [10:0]   res_q, res_d;

  logic [15:0]        omega_dc;
  logic [15:0]        dmin;
  logic signed [17:0] d_raw;
  logic [15:0]        d_clamp;
  logic [NW-1:0]      num;
  logic [17:0]        rem_sh;
  logic               ge;
  logic [16:0]        rem_nx;
  logic [NW-1:0]      quo_nx;
  logic [10:0]        quo_sat;

  // Denominator is formed in A<<8 units; negative or tiny values fall to the t0 floor.
  always_comb begin
    omega_dc = 16'(OMEGA_C) * 16'(dc_q);
    dmin     = 16'(T0_C) * 16'(a_q);
    d_raw    = $signed({2'b00, a_q, 8'd0}) - $signed({2'b00, omega_dc});
    d_clamp  = (d_raw < $signed({2'b00, dmin})) ? dmin : d_raw[15:0];
`ifdef DEHAZE_RECIP_ROUND_EN
    num      = {1'b0, a_q, 11'd0} + {5'd0, d_clamp[15:1]};
`else
    num      = {a_q, 11'd0};
`endif
  end

  always_comb begin
    rem_sh  = {rem_q, quo_q[NW-1]};
    ge      = (rem_sh >= {2'b00, d_q});
    rem_nx  = ge ? 17'(rem_sh - {2'b00, d_q}) : rem_sh[16:0];
    quo_nx  = {quo_q[NW-2:0], ge};
    quo_sat = (|quo_nx[NW-1:11]) ? 11'd2047 : quo_nx[10:0];
  end

  always_comb begin
    state_d = state_q;
    dc_d    = dc_q;
    a_d     = a_q;
    er_d    = er_q;
    eg_d    = eg_q;
    eb_d    = eb_q;
    d_d     = d_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_valid) begin
          dc_d    = bus.i_dc;
          a_d     = bus.i_a;
          er_d    = bus.i_er;
          eg_d    = bus.i_eg;
          eb_d    = bus.i_eb;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        // A == 0 would divide by zero; define 1/t as 1.0 instead.
        if (a_q == 8'd0) begin
          res_d   = 11'd8;
          state_d = ST_DONE;
        end else begin
          d_d     = d_clamp;
          rem_d   = 17'd0;
          quo_d   = num;
          cnt_d   = ITER_LAST;
          state_d = ST_DIV;
        end
      end
      ST_DIV: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        if (cnt_q == 5'd0) begin
          res_d   = quo_sat;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_DONE: begin
        if (bus.i_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      dc_q    <= '0;
      a_q     <= '0;
      er_q    <= '0;
      eg_q    <= '0;
      eb_q    <= '0;
      d_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      dc_q    <= dc_d;
      a_q     <= a_d;
      er_q    <= er_d;
      eg_q    <= eg_d;
      eb_q    <= eb_d;
      d_q     <= d_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign bus.o_ready   = (state_q == ST_IDLE);
  assign bus.o_valid   = (state_q == ST_DONE);
  assign bus.o_on_by_t = res_q;
  assign bus.o_er      = er_q;
  assign bus.o_eg      = eg_q;
  assign bus.o_eb      = eb_q;
  assign bus.o_a       = a_q;

endmodule

`default_nettype wire

// File: tb/tb_transmission_reciprocal.sv
// Bench for transmission_reciprocal: directed and random pixels against an arithmetic model.
`default_nettype none

module tb_transmission_reciprocal;
  localparam int OMEGA = 243;
  localparam int T0    = 26;
`ifdef DEHAZE_RECIP_ROUND_EN
  localparam int LAT = 22;
`else
  localparam int LAT = 21;
`endif

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  transmission_reciprocal_if bus ();

  transmission_reciprocal #(.OMEGA(OMEGA), .T0(T0)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model(input int a, input int dc);
    int d, n, q;
    if (a == 0) return 8;
    d = a * 256 - OMEGA * dc;
    if (d < T0 * a) d = T0 * a;
    n = a * 2048;
`ifdef DEHAZE_RECIP_ROUND_EN
    n = n + d / 2;
`endif
    q = n / d;
    return (q > 2047) ? 2047 : q;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Launches one pixel and waits for o_valid; leaves the DUT in DONE.
  task automatic send(input int a, input int dc, input int er, input int eg, input int eb,
                      input string tag);
    int lat;
    @(negedge clk);
    check({tag, ".ready"}, {31'd0, bus.o_ready}, 32'd1);
    bus.i_valid = 1'b1;
    bus.i_a  = 8'(a);
    bus.i_dc = 8'(dc);
    bus.i_er = 8'(er);
    bus.i_eg = 8'(eg);
    bus.i_eb = 8'(eb);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    lat = 1;
    while (!bus.o_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".valid"}, {31'd0, bus.o_valid}, 32'd1);
    check({tag, ".lat"}, 32'(lat), (a == 0) ? 32'd2 : 32'(LAT));
    check({tag, ".recip"}, 32'(bus.o_on_by_t), 32'(model(a, dc)));
    check({tag, ".side"}, {bus.o_a, bus.o_er, bus.o_eg, bus.o_eb},
          {8'(a), 8'(er), 8'(eg), 8'(eb)});
    check({tag, ".nready"}, {31'd0, bus.o_ready}, 32'd0);
  endtask

  task automatic release_done(input string tag);
    @(negedge clk);
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, ".drop"}, {30'd0, bus.o_valid, bus.o_ready}, 32'd1);
  endtask

  initial begin
    int a, dc;
    logic [10:0] held_r;
    logic [31:0] held_s;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_a = '0; bus.i_dc = '0;
    bus.i_er = '0; bus.i_eg = '0; bus.i_eb = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.valid", {31'd0, bus.o_valid}, 32'd0);
    check("rst.ready", {31'd0, bus.o_ready}, 32'd1);
    check("rst.recip", 32'(bus.o_on_by_t), 32'd0);
    check("rst.side", {bus.o_a, bus.o_er, bus.o_eg, bus.o_eb}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    send(200, 0, 11, 22, 33, "a200dc0");     release_done("a200dc0");
    send(200, 100, 1, 2, 3, "a200dc100");    release_done("a200dc100");
    send(200, 200, 4, 5, 6, "a200dc200");    release_done("a200dc200");
    send(50, 255, 7, 8, 9, "a50dc255");      release_done("a50dc255");
    send(0, 123, 10, 20, 30, "a0");          release_done("a0");
    send(255, 255, 255, 255, 255, "maxall"); release_done("maxall");
    send(1, 0, 0, 0, 0, "a1dc0");            release_done("a1dc0");

    for (int i = 0; i < 16; i++) begin
      a  = (i % 5 == 4) ? 0 : int'($urandom_range(255, 0));
      dc = int'($urandom_range(255, 0));
      send(a, dc, int'($urandom_range(255, 0)), int'($urandom_range(255, 0)),
           int'($urandom_range(255, 0)), "rand");
      release_done("rand");
    end

    // Backpressure: outputs frozen while new requests are offered.
    bus.i_ready = 1'b0;
    send(200, 100, 77, 88, 99, "bp");
    held_r = bus.o_on_by_t;
    held_s = {bus.o_a, bus.o_er, bus.o_eg, bus.o_eb};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.i_valid = 1'b1;
      bus.i_a  = 8'(k + 3);
      bus.i_dc = 8'(k * 7);
      bus.i_er = 8'(k);
      @(posedge clk);
      #1;
      check("bp.hold", {bus.o_valid, bus.o_ready, 19'd0, bus.o_on_by_t},
            {1'b1, 1'b0, 19'd0, held_r});
      check("bp.side", {bus.o_a, bus.o_er, bus.o_eg, bus.o_eb}, held_s);
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    release_done("bp");
    send(120, 60, 5, 6, 7, "bp.next");
    release_done("bp.next");

    // Asynchronous reset in the middle of a division.
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_a  = 8'd200;
    bus.i_dc = 8'd150;
    bus.i_er = 8'd1;
    bus.i_eg = 8'd2;
    bus.i_eb = 8'd3;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid.valid", {31'd0, bus.o_valid}, 32'd0);
    check("mid.ready", {31'd0, bus.o_ready}, 32'd1);
    check("mid.recip", 32'(bus.o_on_by_t), 32'd0);
    check("mid.side", {bus.o_a, bus.o_er, bus.o_eg, bus.o_eb}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(200, 0, 9, 8, 7, "post");
    check("post.eight", 32'(bus.o_on_by_t), 32'd8);
    release_done("post");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/transmission_reciprocal.md
Name: transmission_reciprocal

Overview:
- Upstream neighbour of the scene restoration stage; produces the 11-bit inverse transmission (1/t, unsigned Q8.3) that the restoration stage consumes.
- Per pixel, computes 1/t = A / (A − ω·dc) with a t ≥ t0 floor, using a serial radix-2 restoring divider.
- Inputs are the dark-channel value dc and the local atmospheric light A.
- Carries the pixel RGB and A alongside the result, so outputs arrive aligned at the restoration inputs.
- Valid/ready handshake on both sides; one pixel in flight.

Parameters:
- OMEGA, 243, haze retention factor ω in Q0.8 (243 ≈ 0.95); legal range 0..255.
- T0, 26, minimum transmission t0 in Q0.8 (26 ≈ 0.1); legal range 1..255.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  input pixel valid.
- o_ready  out  1  block can accept; high only in IDLE.
- i_dc  in  8  dark-channel value.
- i_a  in  8  atmospheric light (min of local Ar/Ag/Ab).
- i_er, i_eg, i_eb  in  8 each  hazy pixel RGB sidecar.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts.
- o_on_by_t  out  11  1/t, unsigned Q8.3.
- o_er, o_eg, o_eb, o_a  out  8 each  registered sidecar copies.

Behaviour:
- Reset (asynchronous, any state, including mid-division):
  - state = IDLE.
  - o_valid = 0, o_ready = 1.
  - o_on_by_t, o_er, o_eg, o_eb, o_a = 0.
  - Divider registers cleared. No partial result is ever emitted.
- States: IDLE → SETUP → DIV → DONE → IDLE.
- IDLE:
  - o_ready = 1.
  - On i_valid & o_ready: capture i_dc, i_a and the sidecars; go to SETUP.
- SETUP (1 cycle):
  - N = i_a << 11 (19 bits).
  - D = (A << 8) − OMEGA·dc, held as signed 18-bit.
  - Dmin = T0·A (16 bits).
  - If D < Dmin (includes negative D): D = Dmin.
  - If A == 0: bypass the divider; result = 8 (1.0); go directly to DONE.
  - Otherwise: load remainder = 0, quotient = N, iteration counter = 18; go to DIV.
- DIV (19 cycles):
  - Each cycle: shift {remainder, quotient} left by 1.
  - If remainder ≥ D: subtract D and set the quotient LSB.
  - Decrement the counter; leave DIV when the counter reaches 0.
- Final result:
  - Quotient truncated, i.e. floor(N/D).
  - Saturate to 2047 if the quotient is > 2047 (reachable only when T0 is small).
  - Result is registered into o_on_by_t when entering DONE.
- DONE:
  - o_valid = 1; o_ready = 0.
  - Outputs held stable while i_ready = 0.
  - On i_ready: o_valid drops next cycle and state returns to IDLE.
  - No same-cycle re-accept; at most one pixel is in flight.
- Latency (normal path): o_valid rises 21 edges after the accepting edge.
- Latency (A == 0 bypass): o_valid rises 2 edges after the accepting edge.
- Throughput: one pixel per 22 cycles with i_ready held high.
- Inputs are ignored outside IDLE. i_valid held high while o_ready = 0 has no effect.
- Widths:
  - OMEGA·dc is at most 65025 (16 bits).
  - A << 8 is at most 65280.
  - The subtraction needs a sign bit.
  - Remainder needs 17 bits (D up to 65280).
- The sidecar registers update only on acceptance.

Optional Feature:
- Macro: DEHAZE_RECIP_ROUND_EN.
- Defined:
  - Result is rounded to nearest, ties up.
  - In SETUP, the numerator becomes N' = (A << 11) + (D >> 1), using the clamped D.
  - N' widens to 20 bits and DIV runs 20 iterations, so normal latency is 22 edges.
  - Saturation to 2047 is still applied.
- Undefined: truncating division exactly as described under Behaviour.

Test Plan:
- A = 200, dc = 0 → D = 51200, o_on_by_t = 8. Latency 21 edges (22 with rounding); sidecars equal the inputs.
- A = 200, dc = 100 → D = 26900, o_on_by_t = 15 (15 with rounding).
- A = 200, dc = 200 → raw D = 2600, clamped to Dmin = 5200, o_on_by_t = 78 (79 with rounding).
- A = 50, dc = 255 (negative D) → clamped to 1300, o_on_by_t = 78. Separately, A = 0 → o_on_by_t = 8 after 2 edges.
- Backpressure: hold i_ready = 0 for 10 cycles in DONE → o_valid and all outputs stable, o_ready = 0, new i_valid ignored. Release i_ready → next pixel accepted in IDLE.
- Assert i_rst_n = 0 mid-DIV (cycle 10) → o_valid = 0 and outputs = 0 immediately. After release, a fresh pixel (A = 200, dc = 0) yields 8.
